// File: rtl/uart_tx.sv
// uart_tx: baud-tick driven UART transmitter with a one-byte holding register.
// Frames are start, DATA_BITS data bits (LSB first), optional parity, STOP_BITS stop bits.
module uart_tx #(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic       in_clk,
  input  logic       rst,
  input  logic       baud_tick,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       busy
);

  // state    | meaning
  // S_IDLE   | line high, waiting for a held byte on a tick
  // S_START  | start bit (0) on the line
  // S_DATA   | data bit shift[0] on the line, cnt = data bits still to follow
  // S_PARITY | parity bit on the line
  // S_STOP   | stop bit on the line, cnt = stop bits still to follow
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  localparam logic [7:0] DATA_MASK = 8'(8'hFF >> (8 - DATA_BITS));
  localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);
  localparam logic       PAR_INV   = (PARITY == 2);

  state_t     state, state_nxt;
  logic [7:0] hold_reg;
  logic       hold_full, hold_full_nxt;
  logic [7:0] shift, shift_nxt;
  logic [2:0] cnt, cnt_nxt;
  logic       par_bit, par_nxt;
  logic       tx_nxt, tx_ready_nxt, busy_nxt;
  logic       accept, load;

  always_comb begin
    state_nxt     = state;
    shift_nxt     = shift;
    cnt_nxt       = cnt;
    par_nxt       = par_bit;
    tx_nxt        = tx;
    hold_full_nxt = hold_full;
    load          = 1'b0;
    accept        = tx_valid && tx_ready;

    if (accept) hold_full_nxt = 1'b1;

    if (baud_tick) begin
      case (state)
        S_IDLE: begin
          if (hold_full) load = 1'b1;
        end
        S_START: begin
          tx_nxt    = shift[0];
          cnt_nxt   = LAST_DATA;
          state_nxt = S_DATA;
        end
        S_DATA: begin
          if (cnt != 3'd0) begin
            cnt_nxt   = cnt - 3'd1;
            shift_nxt = shift >> 1;
            tx_nxt    = shift[1];
          end else if (PARITY != 0) begin
            tx_nxt    = par_bit;
            state_nxt = S_PARITY;
          end else begin
            tx_nxt    = 1'b1;
            cnt_nxt   = LAST_STOP;
            state_nxt = S_STOP;
          end
        end
        S_PARITY: begin
          tx_nxt    = 1'b1;
          cnt_nxt   = LAST_STOP;
          state_nxt = S_STOP;
        end
        S_STOP: begin
          if (cnt != 3'd0)   cnt_nxt   = cnt - 3'd1;
          else if (hold_full) load     = 1'b1;
          else               state_nxt = S_IDLE;
        end
        default: state_nxt = S_IDLE;
      endcase
    end

    // Loading the shifter drains the holding register and puts the start bit out.
    if (load) begin
      shift_nxt     = hold_reg;
      par_nxt       = (^hold_reg) ^ PAR_INV;
      tx_nxt        = 1'b0;
      state_nxt     = S_START;
      hold_full_nxt = 1'b0;
    end

    // Ready drops on the accepting edge but only reopens a cycle after a drain.
    tx_ready_nxt = accept ? 1'b0 : !hold_full;
    busy_nxt     = (state_nxt != S_IDLE) || hold_full_nxt;
  end

  always_ff @(posedge in_clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      hold_reg  <= '0;
      hold_full <= 1'b0;
      shift     <= '0;
      cnt       <= '0;
      par_bit   <= 1'b0;
      tx        <= 1'b1;
      tx_ready  <= 1'b1;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      hold_full <= hold_full_nxt;
      shift     <= shift_nxt;
      cnt       <= cnt_nxt;
      par_bit   <= par_nxt;
      tx        <= tx_nxt;
      tx_ready  <= tx_ready_nxt;
      busy      <= busy_nxt;
      if (accept) hold_reg <= tx_data & DATA_MASK;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: three transmitter configurations checked against a frame-level model:
// 8N1 (index 0), 7 bits even parity 2 stop (index 1), 7 bits odd parity 2 stop (index 2).
module tb_uart_tx;

  logic       in_clk = 1'b0;
  logic       rst = 1'b0;
  logic       baud_tick = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic [2:0] tx_valid = 3'b000;
  logic [2:0] tx_ready, tx, busy;

  int n_checks = 0;
  int n_fail = 0;
  int tick_period = 16;

  int db_cfg[3]  = '{8, 7, 7};
  int par_cfg[3] = '{0, 1, 2};
  int sb_cfg[3]  = '{1, 2, 2};

  typedef struct {
    int         idx;
    logic [7:0] data;
    int         len;
    logic [31:0] exp;
  } vec_t;

  always #5 in_clk = ~in_clk;

  uart_tx #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .in_clk(in_clk), .rst(rst), .baud_tick(baud_tick), .tx_data(tx_data),
    .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]), .tx(tx[0]), .busy(busy[0]));
  uart_tx #(.DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u_7e2 (
    .in_clk(in_clk), .rst(rst), .baud_tick(baud_tick), .tx_data(tx_data),
    .tx_valid(tx_valid[1]), .tx_ready(tx_ready[1]), .tx(tx[1]), .busy(busy[1]));
  uart_tx #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u_7o2 (
    .in_clk(in_clk), .rst(rst), .baud_tick(baud_tick), .tx_data(tx_data),
    .tx_valid(tx_valid[2]), .tx_ready(tx_ready[2]), .tx(tx[2]), .busy(busy[2]));

  // Baud pulse: one cycle in every tick_period, changed just after the rising edge.
  initial begin
    int cnt = 0;
    forever begin
      @(posedge in_clk);
      #1;
      cnt++;
      if (cnt >= tick_period) begin
        cnt = 0;
        baud_tick = 1'b1;
      end else begin
        baud_tick = 1'b0;
      end
    end
  end

  // The line may only move on an edge that carried a baud tick (outside reset).
  logic [2:0] tx_prev = 3'b111;
  logic       rst_q = 1'b0;
  logic       tick_pending = 1'b0;
  always @(negedge in_clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst && rst_q && tx[i] !== tx_prev[i]) begin
        n_checks++;
        if (!tick_pending) begin
          n_fail++;
          $display("FAIL tx_change_without_tick[%0d]: tx went to %b, required to hold %b", i, tx[i], tx_prev[i]);
        end
      end
    end
    tx_prev = tx;
    rst_q = rst;
    tick_pending = baud_tick;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out waiting, got no event, required one", name);
  endtask

  // Reference frame: bit k of the result is the line level during the k-th bit period.
  function automatic int frame_len(input int idx);
    return 1 + db_cfg[idx] + ((par_cfg[idx] != 0) ? 1 : 0) + sb_cfg[idx];
  endfunction

  function automatic logic [31:0] frame_bits(input int idx, input logic [7:0] d);
    logic [31:0] bits = '0;
    int pos = 1;
    int ones = 0;
    for (int i = 0; i < db_cfg[idx]; i++) begin
      bits[pos] = d[i];
      ones += int'(d[i]);
      pos++;
    end
    if (par_cfg[idx] == 1) begin
      bits[pos] = 1'(ones % 2);
      pos++;
    end else if (par_cfg[idx] == 2) begin
      bits[pos] = 1'((ones + 1) % 2);
      pos++;
    end
    for (int s = 0; s < sb_cfg[idx]; s++) begin
      bits[pos] = 1'b1;
      pos++;
    end
    return bits;
  endfunction

  // Returns 2 ns after the next edge that carries a baud tick.
  task automatic wait_tick();
    int guard = 0;
    do begin
      @(posedge in_clk);
      guard++;
    end while (!baud_tick && guard < 100);
    if (!baud_tick) timeout("wait_tick");
    #2;
  endtask

  task automatic send(input int idx, input logic [7:0] d);
    int guard = 0;
    while (!tx_ready[idx] && guard < 400) begin
      @(posedge in_clk);
      #2;
      guard++;
    end
    if (!tx_ready[idx]) timeout("send_ready");
    tx_data = d;
    tx_valid[idx] = 1'b1;
    @(posedge in_clk);
    #2;
    tx_valid[idx] = 1'b0;
  endtask

  task automatic collect(input int idx, input int n, output logic [31:0] got, output logic [31:0] rdy);
    got = '0;
    rdy = '0;
    for (int k = 0; k < n; k++) begin
      wait_tick();
      got[k] = tx[idx];
      rdy[k] = tx_ready[idx];
    end
  endtask

  initial begin
    vec_t vecs[7];
    logic [31:0] got, rdy, exp;
    int guard;
    int idx;
    logic [7:0] d;

    vecs[0] = '{0, 8'hA5, 10, 32'h34A};
    vecs[1] = '{0, 8'h00, 10, 32'h200};
    vecs[2] = '{0, 8'hFF, 10, 32'h3FE};
    vecs[3] = '{1, 8'h83, 11, 32'h606};
    vecs[4] = '{2, 8'h83, 11, 32'h706};
    vecs[5] = '{1, 8'h55, 11, 32'h6AA};
    vecs[6] = '{2, 8'h55, 11, 32'h7AA};

    // Reset state.
    repeat (3) @(posedge in_clk);
    #2;
    check("reset_tx", 32'(tx), 32'h7);
    check("reset_ready", 32'(tx_ready), 32'h7);
    check("reset_busy", 32'(busy), 32'h0);
    rst = 1'b1;
    repeat (20) @(posedge in_clk);
    #2;

    // 0xA5 on 8N1 with the ready-reopen timing around the start tick.
    send(0, 8'hA5);
    check("a5_busy_after_accept", 32'(busy[0]), 32'h1);
    wait_tick();
    check("a5_start", 32'(tx[0]), 32'h0);
    check("a5_ready_at_start_tick", 32'(tx_ready[0]), 32'h0);
    @(posedge in_clk);
    #2;
    check("a5_ready_cycle_after", 32'(tx_ready[0]), 32'h1);
    collect(0, 9, got, rdy);
    check("a5_frame", got, frame_bits(0, 8'hA5) >> 1);
    wait_tick();
    check("a5_busy_end", 32'(busy[0]), 32'h0);

    // Fixed vectors.
    for (int v = 0; v < 7; v++) begin
      send(vecs[v].idx, vecs[v].data);
      collect(vecs[v].idx, vecs[v].len, got, rdy);
      check($sformatf("vec%0d_frame", v), got, vecs[v].exp);
      wait_tick();
      check($sformatf("vec%0d_busy_end", v), 32'(busy[vecs[v].idx]), 32'h0);
      check($sformatf("vec%0d_ready_end", v), 32'(tx_ready[vecs[v].idx]), 32'h1);
    end

    // Back-to-back: 0x00 then 0xFF as soon as ready reopens, no idle between frames.
    send(0, 8'h00);
    send(0, 8'hFF);
    check("b2b_ready_after_accept", 32'(tx_ready[0]), 32'h0);
    check("b2b_first_start", 32'(tx[0]), 32'h0);
    collect(0, 19, got, rdy);
    exp = (frame_bits(0, 8'h00) | (frame_bits(0, 8'hFF) << 10)) >> 1;
    check("b2b_stream", got, exp);
    check("b2b_ready_low_until_start2", rdy & 32'h3FF, 32'h0);
    check("b2b_ready_after_start2", 32'(rdy[10]), 32'h1);
    wait_tick();
    check("b2b_busy_end", 32'(busy[0]), 32'h0);

    // Reset during data bit 3 with a second byte held.
    send(0, 8'hC3);
    send(0, 8'h3C);
    repeat (4) wait_tick();
    check("rst_mid_bit3", 32'(tx[0]), 32'h0);
    check("rst_mid_busy", 32'(busy[0]), 32'h1);
    #3;
    rst = 1'b0;
    #1;
    check("rst_mid_tx", 32'(tx[0]), 32'h1);
    check("rst_mid_ready", 32'(tx_ready[0]), 32'h1);
    check("rst_mid_busy_low", 32'(busy[0]), 32'h0);
    repeat (20) @(posedge in_clk);
    #2;
    check("rst_hold_all", {29'd0, tx[0], tx_ready[0], busy[0]}, 32'h6);
    rst = 1'b1;
    wait_tick();
    wait_tick();
    check("rst_after_idle", {29'd0, tx[0], tx_ready[0], busy[0]}, 32'h6);
    send(0, 8'h55);
    collect(0, 10, got, rdy);
    check("rst_after_55", got, frame_bits(0, 8'h55));
    wait_tick();

    // Accept coincident with a tick while idle: that tick is not used.
    guard = 0;
    do begin
      @(posedge in_clk);
      #2;
      guard++;
    end while (!baud_tick && guard < 100);
    if (!baud_tick) timeout("align_tick");
    tx_data = 8'h5A;
    tx_valid[0] = 1'b1;
    @(posedge in_clk);
    #2;
    tx_valid[0] = 1'b0;
    check("coinc_tx_high", 32'(tx[0]), 32'h1);
    check("coinc_ready_low", 32'(tx_ready[0]), 32'h0);
    collect(0, 10, got, rdy);
    check("coinc_frame", got, frame_bits(0, 8'h5A));
    wait_tick();

    // Random bytes, configurations and baud rates.
    for (int r = 0; r < 24; r++) begin
      idx = int'($urandom_range(0, 2));
      d = 8'($urandom);
      tick_period = int'($urandom_range(1, 20));
      send(idx, d);
      collect(idx, frame_len(idx), got, rdy);
      check($sformatf("rand%0d_cfg%0d_%02h", r, idx, d), got, frame_bits(idx, d));
      wait_tick();
      check($sformatf("rand%0d_busy_end", r), 32'(busy[idx]), 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation still running, required to have finished");
    $fatal(1, "watchdog expired");
  end

endmodule
